// File: rtl/clip_memory.sv
// clip_memory: two-bank audio clip store serving the controller's memory
// requests. Deserializer samples are written into bank 0 or bank 1, and
// playback reads return samples to the serializer. Each bank tracks its
// recorded clip length so reads past the end of a clip return silence.
//
// Ports:
//   clock_i, reset_i      clock and synchronous active-high reset
//   memory_addr_i         sample address of the request
//   memory_rw_i           1 = write, 0 = read
//   memory_0/1_enable_i   bank select (exactly one high = valid request)
//   write_data_i          sample to store, sampled with the request
//   read_data_o           read sample (meaningful while read_valid_o)
//   read_valid_o          one pulse per completed read (request + 2 cycles)
//   write_ack_o           one pulse per committed write (request + 1 cycle)
//   error_o               one pulse per rejected request (request + 1 cycle)
//   clip_0/1_length_o     number of valid samples in each bank
module clip_memory #(
    parameter int WORD_LENGTH = 14,
    parameter int DEPTH       = 12000,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [WORD_LENGTH-1:0] memory_addr_i,
    input  logic                   memory_rw_i,
    input  logic                   memory_0_enable_i,
    input  logic                   memory_1_enable_i,
    input  logic [DATA_WIDTH-1:0]  write_data_i,
    output logic [DATA_WIDTH-1:0]  read_data_o,
    output logic                   read_valid_o,
    output logic                   write_ack_o,
    output logic                   error_o,
    output logic [WORD_LENGTH:0]   clip_0_length_o,
    output logic [WORD_LENGTH:0]   clip_1_length_o
);

    localparam int                NUM_BANKS = 2;
    localparam int                LEN_W     = WORD_LENGTH + 1;
    localparam int                RD_STAGES = 2;
    localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

    typedef struct packed {
        logic                   vld;   // accepted: one bank, in range, not in reset
        logic                   rw;
        logic                   bank;
        logic [WORD_LENGTH-1:0] addr;
        logic [DATA_WIDTH-1:0]  data;
    } req_t;

    req_t                                req;
    logic                                req_err;
    logic                                one_bank;
    logic                                addr_ok;
    logic                                req_in_len;
    logic [LEN_W-1:0]                    addr_p1;
    logic [NUM_BANKS-1:0][LEN_W-1:0]     clip_len;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_q;
    logic [RD_STAGES:1]                  vld_pipe;
    logic                                s1_bank;
    logic                                s1_in_len;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        one_bank = memory_0_enable_i ^ memory_1_enable_i;
        addr_ok  = {1'b0, memory_addr_i} < DEPTH_LEN;

        req      = '0;
        req.vld  = one_bank & addr_ok & ~reset_i;
        req.rw   = memory_rw_i;
        req.bank = memory_1_enable_i;
        req.addr = memory_addr_i;
        req.data = write_data_i;

        // Both enables, or a single enable with an out-of-range address.
        req_err  = (memory_0_enable_i & memory_1_enable_i) | (one_bank & ~addr_ok);
    end

    // Reads compare against the live length register, so a write in the
    // previous cycle has already extended the clip.
    assign req_in_len = {1'b0, req.addr} < clip_len[req.bank];
    assign addr_p1    = {1'b0, req.addr} + LEN_ONE;

    // ------------------------------------------------------------------
    // Banks: single-port RAM plus clip length tracker
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;
        logic [LEN_W-1:0]      len_q;
        logic                  en;

        assign en        = req.vld && (req.bank == 1'(b));
        assign bank_q[b] = rd_q;
        assign clip_len[b] = len_q;

        // No reset here so the array and its read register map onto block RAM;
        // old contents survive reset and are hidden by the cleared length.
        always_ff @(posedge clock_i) begin
            if (en) begin
                if (req.rw) mem[req.addr] <= req.data;
                else        rd_q          <= mem[req.addr];
            end
        end

        // Address 0 starts a fresh recording. Accepted addresses are below
        // DEPTH, so addr+1 can never push the length past DEPTH.
        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                len_q <= '0;
            end else if (en && req.rw) begin
                if (req.addr == '0)       len_q <= LEN_ONE;
                else if (addr_p1 > len_q) len_q <= addr_p1;
            end
        end
    end

    assign clip_0_length_o = clip_len[0];
    assign clip_1_length_o = clip_len[1];

    // ------------------------------------------------------------------
    // Read pipeline and response pulses
    //   stage 1: RAM read register (in bank) + bank / in-length flags
    //   stage 2: output register, silence for reads past the clip end
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            vld_pipe    <= '0;
            s1_bank     <= 1'b0;
            s1_in_len   <= 1'b0;
            read_data_o <= '0;
            write_ack_o <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            vld_pipe[1] <= req.vld & ~req.rw;
            vld_pipe[2] <= vld_pipe[1];
            s1_bank     <= req.bank;
            s1_in_len   <= req_in_len;
            read_data_o <= (vld_pipe[1] && s1_in_len) ? bank_q[s1_bank] : '0;
            write_ack_o <= req.vld & req.rw;
            error_o     <= req_err;
        end
    end

    assign read_valid_o = vld_pipe[RD_STAGES];

endmodule

// File: tb/tb_clip_memory.sv
module tb_clip_memory;
    localparam int WL    = 14;
    localparam int DEPTH = 12000;
    localparam int DW    = 16;
    localparam int MAXC  = 4096;

    logic            clock_i = 1'b0;
    logic            reset_i = 1'b1;
    logic [WL-1:0]   memory_addr_i = '0;
    logic            memory_rw_i = 1'b0;
    logic            memory_0_enable_i = 1'b0;
    logic            memory_1_enable_i = 1'b0;
    logic [DW-1:0]   write_data_i = '0;
    logic [DW-1:0]   read_data_o;
    logic            read_valid_o;
    logic            write_ack_o;
    logic            error_o;
    logic [WL:0]     clip_0_length_o;
    logic [WL:0]     clip_1_length_o;

    always #5 clock_i = ~clock_i;

    clip_memory #(.WORD_LENGTH(WL), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .memory_addr_i    (memory_addr_i),
        .memory_rw_i      (memory_rw_i),
        .memory_0_enable_i(memory_0_enable_i),
        .memory_1_enable_i(memory_1_enable_i),
        .write_data_i     (write_data_i),
        .read_data_o      (read_data_o),
        .read_valid_o     (read_valid_o),
        .write_ack_o      (write_ack_o),
        .error_o          (error_o),
        .clip_0_length_o  (clip_0_length_o),
        .clip_1_length_o  (clip_1_length_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected outputs per cycle, filled in when the request is issued.
    bit          e_vld  [MAXC];
    bit          e_known[MAXC];
    bit          e_ack  [MAXC];
    bit          e_err  [MAXC];
    logic [15:0] e_data [MAXC];
    int          e_len0 [MAXC];
    int          e_len1 [MAXC];

    // Behavioural clip store: sample arrays, written flags, clip lengths.
    logic [15:0] m_mem [2][DEPTH];
    bit          m_wr  [2][DEPTH];
    int          m_len [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: check this cycle's outputs, drive this cycle's request,
    // then advance the reference model.
    task automatic cycle(input bit rst, input bit en0, input bit en1, input bit rw,
                         input int addr, input logic [15:0] d);
        int b;
        @(posedge clock_i);
        #1;
        cyc++;
        if (cyc + 2 >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        check("read_valid", read_valid_o, e_vld[cyc]);
        check("write_ack", write_ack_o, e_ack[cyc]);
        check("error", error_o, e_err[cyc]);
        check("len0", clip_0_length_o, e_len0[cyc]);
        check("len1", clip_1_length_o, e_len1[cyc]);
        if (e_vld[cyc] && e_known[cyc]) check("read_data", read_data_o, e_data[cyc]);

        reset_i           = rst;
        memory_0_enable_i = en0;
        memory_1_enable_i = en1;
        memory_rw_i       = rw;
        memory_addr_i     = addr[WL-1:0];
        write_data_i      = d;

        if (rst) begin
            m_len = '{0, 0};
            e_vld[cyc+1] = 1'b0;
            e_ack[cyc+1] = 1'b0;
            e_err[cyc+1] = 1'b0;
        end else begin
            e_ack[cyc+1] = 1'b0;
            e_err[cyc+1] = 1'b0;
            if (en0 && en1) begin
                e_err[cyc+1] = 1'b1;
            end else if (en0 || en1) begin
                b = en1 ? 1 : 0;
                if (addr >= DEPTH) begin
                    e_err[cyc+1] = 1'b1;
                end else if (rw) begin
                    m_mem[b][addr] = d;
                    m_wr[b][addr]  = 1'b1;
                    if (addr == 0) m_len[b] = 1;
                    else if (addr + 1 > m_len[b]) m_len[b] = addr + 1;
                    e_ack[cyc+1] = 1'b1;
                end else begin
                    e_vld[cyc+2] = 1'b1;
                    if (addr < m_len[b]) begin
                        e_data[cyc+2]  = m_mem[b][addr];
                        e_known[cyc+2] = m_wr[b][addr];
                    end else begin
                        e_data[cyc+2]  = 16'h0000;
                        e_known[cyc+2] = 1'b1;
                    end
                end
            end
        end
        e_len0[cyc+1] = m_len[0];
        e_len1[cyc+1] = m_len[1];
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    endtask

    initial begin
        int r, addr;
        bit en0, en1;
        m_len = '{0, 0};

        // Cycle 0 is a reset cycle; hold reset one more.
        cycle(1'b1, 0, 0, 0, 0, 16'h0);
        idle();
        check("reset_len0", clip_0_length_o, 0);
        check("reset_valid", read_valid_o, 0);

        // Two writes to bank 0.
        cycle(0, 1, 0, 1, 0, 16'h1234);
        cycle(0, 1, 0, 1, 1, 16'h5678);
        check("wr0_ack", write_ack_o, 1);
        check("wr0_len", clip_0_length_o, 1);
        idle();
        check("wr1_ack", write_ack_o, 1);
        check("wr1_len0", clip_0_length_o, 2);
        check("wr1_len1", clip_1_length_o, 0);

        // Back-to-back reads of 0, 1, 2.
        cycle(0, 1, 0, 0, 0, 16'h0);
        cycle(0, 1, 0, 0, 1, 16'h0);
        cycle(0, 1, 0, 0, 2, 16'h0);
        check("rd0_data", read_data_o, 16'h1234);
        idle();
        check("rd1_data", read_data_o, 16'h5678);
        idle();
        check("rd2_valid", read_valid_o, 1);
        check("rd2_data", read_data_o, 16'h0000);
        check("rd2_err", error_o, 0);

        // Both enables, then address DEPTH.
        cycle(0, 1, 1, 1, 5, 16'hdead);
        idle();
        check("both_err", error_o, 1);
        check("both_ack", write_ack_o, 0);
        cycle(0, 1, 0, 1, DEPTH, 16'hbeef);
        idle();
        check("oor_err", error_o, 1);
        check("oor_len0", clip_0_length_o, 2);

        // Fill bank 1 to 100, restart at 0, then read past new end.
        for (int i = 0; i < 100; i++) cycle(0, 0, 1, 1, i, 16'(i + 16'h100));
        idle();
        check("fill_len1", clip_1_length_o, 100);
        cycle(0, 0, 1, 1, 0, 16'h7777);
        cycle(0, 0, 1, 0, 50, 16'h0);
        check("restart_len1", clip_1_length_o, 1);
        idle();
        idle();
        check("stale_valid", read_valid_o, 1);
        check("stale_data", read_data_o, 16'h0000);

        // Read-after-write to the same address.
        cycle(0, 1, 0, 1, 2, 16'habcd);
        cycle(0, 1, 0, 0, 2, 16'h0);
        idle();
        idle();
        check("raw_data", read_data_o, 16'habcd);

        // Read, then reset in the following cycle.
        cycle(0, 1, 0, 0, 0, 16'h0);
        cycle(1, 0, 0, 0, 0, 16'h0);
        idle();
        check("rst_valid", read_valid_o, 0);
        check("rst_data", read_data_o, 16'h0000);
        check("rst_len0", clip_0_length_o, 0);

        // Pre-load low addresses of both banks, then random traffic.
        for (int i = 0; i < 16; i++) cycle(0, 1, 0, 1, i, 16'($urandom));
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, 1, i, 16'($urandom));
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 99);
            en0 = 1'b0;
            en1 = 1'b0;
            if (r < 5)       begin en0 = 1; en1 = 1; end
            else if (r < 15) begin end
            else if (r < 57) en0 = 1;
            else             en1 = 1;
            r = $urandom_range(0, 9);
            if (r < 6)       addr = $urandom_range(0, 15);
            else if (r < 7)  addr = $urandom_range(DEPTH - 3, DEPTH - 1);
            else if (r < 9)  addr = $urandom_range(DEPTH, (1 << WL) - 1);
            else             addr = $urandom_range(0, DEPTH - 1);
            cycle(($urandom_range(0, 99) < 3), en0, en1, 1'($urandom), addr, 16'($urandom));
        end
        for (int i = 0; i < 4; i++) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clip_memory.md
# clip_memory

Two-bank audio clip store that answers the controller's memory interface: the controller sends address, read/write and bank-enable requests, and this block serves them. Recorded 16-bit samples from the deserializer are written into bank 0 or bank 1. Playback reads return samples for the serializer. The block tracks each clip's recorded length so playback can end at the last recorded sample. It sits between the controller, the deserializer and the serializer in the top level.

## Interface
Parameters:
- WORD_LENGTH, 14, address width of each bank.
- DEPTH, 12000, samples per bank; must satisfy DEPTH <= 2**WORD_LENGTH.
- DATA_WIDTH, 16, sample width.

Ports:
- clock_i  in  1  100 MHz system clock.
- reset_i  in  1  synchronous, active-high reset.
- memory_addr_i  in  WORD_LENGTH  sample address of the request.
- memory_rw_i  in  1  1 = write, 0 = read.
- memory_0_enable_i  in  1  request targets bank 0.
- memory_1_enable_i  in  1  request targets bank 1.
- write_data_i  in  DATA_WIDTH  sample to store; sampled with the request.
- read_data_o  out  DATA_WIDTH  returned sample; meaningful only while read_valid_o is high.
- read_valid_o  out  1  one-cycle pulse per completed read.
- write_ack_o  out  1  one-cycle pulse per committed write.
- error_o  out  1  one-cycle pulse per rejected request.
- clip_0_length_o  out  WORD_LENGTH+1  number of valid samples in bank 0.
- clip_1_length_o  out  WORD_LENGTH+1  number of valid samples in bank 1.

## Operation
- Request handshake:
  - A request is present in any cycle where exactly one bank enable is high.
  - One request is accepted per cycle. The block never stalls and has no ready output.
- Rejection:
  - Both enables high: request dropped; error_o pulses; no ack or valid; no state change.
  - memory_addr_i >= DEPTH: request dropped; error_o pulses.
- Write (rw=1):
  - The sample is stored at the address in the selected bank.
  - write_ack_o pulses.
  - Length update for the selected bank:
    - addr == 0: length <= 1 (a new recording restarts the clip).
    - addr != 0: length <= max(length, addr+1).
- Read (rw=0):
  - addr < length of the selected bank: read_data_o returns the stored sample.
  - addr >= length: read_data_o returns 16'h0000 (silence). read_valid_o still pulses and error_o stays low.
- Read pipeline:
  - Stage 1 is the registered RAM read plus a registered in-range flag.
  - Stage 2 is the output register, which muxes in zero for out-of-range reads.
- Both banks are inferable single-port block RAMs. Only the selected bank is enabled per request.
- Memory contents are not cleared by reset. The clip lengths are cleared, so old data reads as silence until rewritten.

## Timing
- Reset values:
  - read_data_o = 0.
  - read_valid_o = 0, write_ack_o = 0, error_o = 0.
  - clip_0_length_o = 0, clip_1_length_o = 0.
- Write latency: request in cycle N produces write_ack_o high in cycle N+1. Lengths update visibly in cycle N+1.
- Read latency: request in cycle N produces read_valid_o and read_data_o in cycle N+2. Back-to-back reads give one valid per cycle, in request order.
- Error latency: error_o goes high in cycle N+1.
- Read-after-write:
  - Write to address A in cycle N, read of A in cycle N+1: the read returns the new sample in N+3.
  - The length check for that read uses the already-updated length.
- Interleaved write and read to different banks in consecutive cycles are independent. Ack and valid may be high in the same cycle.
- Reset mid-operation:
  - reset_i high in any cycle flushes both pipeline stages.
  - No read_valid_o or write_ack_o is produced for requests issued up to and including the reset cycle.
  - A write issued in the reset cycle is not committed.
- Length saturates at DEPTH. The stored length never exceeds DEPTH.

## Test plan
- Write 16'h1234 to bank 0 at addr 0 and 16'h5678 at addr 1 -> write_ack_o in N+1 and N+2. clip_0_length_o goes 1 then 2; clip_1_length_o stays 0.
- Read bank 0 at addrs 0, 1, 2 back-to-back from cycle M -> read_valid_o high in M+2, M+3, M+4 with data 1234, 5678, 0000; error_o never high.
- Assert both enables with addr 5, rw=1 -> error_o pulse in N+1; no ack; both lengths unchanged.
- Write to addr DEPTH (12000) -> error_o pulse in N+1; no ack; no length change.
- Fill bank 1 to length 100, then write addr 0 -> clip_1_length_o = 1. A subsequent read of addr 50 returns 0000.
- Issue a read in cycle N and assert reset_i in N+1 -> no read_valid_o in N+2. All outputs are 0 and both lengths are 0 in N+2.
